// File: rtl/as5401_core.sv
// 4-bit accumulator core: fetches 8-bit instructions from an async ROM at pc and
// executes one per enabled clock, with a second operand cycle for JMP/taken JC.
module as5401_core (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        en,
   output logic [11:0] pc,
   input  logic [7:0]  instr,
   output logic [7:0]  mem_addr,
   output logic [3:0]  mem_wdata,
   output logic        mem_we,
   input  logic [3:0]  mem_rdata,
   output logic [3:0]  port_out,
   output logic        port_stb,
   output logic        flag_i,
   output logic        flag_c
);

   typedef enum logic {EXEC, OPER} state_t;

   state_t      state_q, state_d;
   logic [3:0]  a_q, a_d;
   logic [7:0]  m_q, m_d;
   logic        c_q, c_d;
   logic        i_q, i_d;
   logic [11:0] pc_q, pc_d;
   logic [3:0]  jh_q, jh_d;
   logic [3:0]  port_q, port_d;
   logic        stb_q, stb_d;
   logic        we;
   logic [4:0]  sum;

   assign sum = {1'b0, a_q} + {1'b0, instr[3:0]};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      c_d     = c_q;
      i_d     = i_q;
      pc_d    = pc_q;
      jh_d    = jh_q;
      port_d  = port_q;
      stb_d   = 1'b0;
      we      = 1'b0;
      if (en) begin
         case (state_q)
            EXEC: begin
               pc_d = pc_q + 12'd1;
               case (instr[7:4])
                  4'h0: begin
                     case (instr[3:0])
                        4'h1: i_d = 1'b1;
                        4'h2: i_d = 1'b0;
                        4'h3: m_d[3:0] = a_q;
                        4'h4: m_d[7:4] = a_q;
                        4'h5: we = 1'b1;
                        4'h6: a_d = mem_rdata;
                        4'h7: begin
                           port_d = a_q;
                           stb_d  = 1'b1;
                        end
                        default: ;
                     endcase
                  end
                  4'h1: a_d = instr[3:0];
                  4'h2: {c_d, a_d} = sum;
                  4'h3: a_d = a_q & instr[3:0];
                  4'h4: a_d = a_q ^ instr[3:0];
                  4'h8: begin
                     jh_d    = instr[3:0];
                     state_d = OPER;
                  end
                  4'h9: begin
                     if (c_q) begin
                        jh_d    = instr[3:0];
                        state_d = OPER;
                     end else begin
                        // Untaken branch steps over its operand byte in one cycle.
                        pc_d = pc_q + 12'd2;
                     end
                  end
                  default: ;
               endcase
            end
            OPER: begin
               pc_d    = {jh_q, instr};
               state_d = EXEC;
            end
            default: state_d = EXEC;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= EXEC;
         a_q     <= 4'd0;
         m_q     <= 8'd0;
         c_q     <= 1'b0;
         i_q     <= 1'b0;
         pc_q    <= 12'd0;
         jh_q    <= 4'd0;
         port_q  <= 4'd0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         c_q     <= c_d;
         i_q     <= i_d;
         pc_q    <= pc_d;
         jh_q    <= jh_d;
         port_q  <= port_d;
         stb_q   <= stb_d;
      end
   end

   // Write strobe is combinational, so it must be masked while reset is held.
   assign mem_we    = we & ~wb_rst_i;
   assign pc        = pc_q;
   assign mem_addr  = m_q;
   assign mem_wdata = a_q;
   assign port_out  = port_q;
   assign port_stb  = stb_q;
   assign flag_i    = i_q;
   assign flag_c    = c_q;

endmodule

// File: tb/tb_as5401_core.sv
// Bench for as5401_core: an instruction-level model predicts OUT values and stores
// into queues that negedge monitors consume, plus end-of-program state checks.
module tb_as5401_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [11:0] pc;
   logic [7:0]  instr;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_wdata;
   logic        mem_we;
   logic [3:0]  mem_rdata;
   logic [3:0]  port_out;
   logic        port_stb;
   logic        flag_i;
   logic        flag_c;

   logic [7:0]  rom  [4096];
   logic [3:0]  dmem [256];

   logic [3:0]  exp_q [$];
   logic [11:0] st_q  [$];

   // Reference model state
   logic [3:0]  ma, mport;
   logic [7:0]  mm;
   logic        mc, mi;
   logic [11:0] mpc;
   logic [3:0]  mmem [256];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign instr     = rom[pc];
   assign mem_rdata = dmem[mem_addr];

   as5401_core dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .en       (en),
      .pc       (pc),
      .instr    (instr),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_rdata(mem_rdata),
      .port_out (port_out),
      .port_stb (port_stb),
      .flag_i   (flag_i),
      .flag_c   (flag_c)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitors: every port strobe and every store is matched against the model.
   logic [3:0]  mon_e;
   logic [11:0] mon_s;
   always @(negedge clk) begin
      if (port_stb === 1'b1) begin
         if (exp_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
         else begin
            mon_e = exp_q.pop_front();
            chk("out_value", {28'd0, port_out}, {28'd0, mon_e});
         end
      end
      if (mem_we === 1'b1) begin
         if (st_q.size() == 0) chk("store_unexpected", 32'd1, 32'd0);
         else begin
            mon_s = st_q.pop_front();
            chk("store_addr_data", {20'd0, mem_addr, mem_wdata}, {20'd0, mon_s});
         end
      end
   end

   // Executes k whole instructions from rom and returns the clocks they take.
   task automatic model_run(input int k, output int cycles);
      logic [7:0]  op;
      logic [11:0] nx;
      int          s;
      cycles = 0;
      for (int n = 0; n < k; n++) begin
         op = rom[mpc];
         nx = mpc + 12'd1;
         cycles++;
         if (op[7:4] == 4'h8 || (op[7:4] == 4'h9 && mc)) begin
            cycles++;
            mpc = {op[3:0], rom[nx]};
         end else if (op[7:4] == 4'h9) begin
            mpc = mpc + 12'd2;
         end else begin
            case (op)
               8'h01: mi = 1'b1;
               8'h02: mi = 1'b0;
               8'h03: mm[3:0] = ma;
               8'h04: mm[7:4] = ma;
               8'h05: begin
                  mmem[mm] = ma;
                  st_q.push_back({mm, ma});
               end
               8'h06: ma = mmem[mm];
               8'h07: begin
                  mport = ma;
                  exp_q.push_back(ma);
               end
               default: begin
                  if (op[7:4] == 4'h1) ma = op[3:0];
                  else if (op[7:4] == 4'h2) begin
                     s  = int'(ma) + int'(op[3:0]);
                     mc = (s > 15);
                     ma = 4'(s % 16);
                  end
                  else if (op[7:4] == 4'h3) ma = ma & op[3:0];
                  else if (op[7:4] == 4'h4) ma = ma ^ op[3:0];
               end
            endcase
            mpc = nx;
         end
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
   endtask

   task automatic random_rom();
      int cls;
      for (int i = 0; i < 4096; i++) begin
         cls = $urandom_range(0, 9);
         case (cls)
            0: rom[i] = 8'($urandom_range(0, 7));
            1: rom[i] = {4'h1, 4'($urandom_range(0, 15))};
            2: rom[i] = {4'h2, 4'($urandom_range(0, 15))};
            3: rom[i] = {4'h3, 4'($urandom_range(0, 15))};
            4: rom[i] = {4'h4, 4'($urandom_range(0, 15))};
            5: rom[i] = {4'h8, 4'($urandom_range(0, 15))};
            6: rom[i] = {4'h9, 4'($urandom_range(0, 15))};
            7: rom[i] = 8'($urandom_range(0, 255));
            default: rom[i] = 8'($urandom_range(3, 7));
         endcase
      end
   endtask

   task automatic init_mem();
      logic [3:0] v;
      for (int i = 0; i < 256; i++) begin
         v = 4'($urandom_range(0, 15));
         dmem[i] = v;
         mmem[i] = v;
      end
   endtask

   task automatic run_test(input string tag, input int k, input bit rnd_en);
      int total, done, iter, bad;
      logic       w;
      logic [7:0] wa;
      logic [3:0] wd;
      ma = 4'd0; mm = 8'd0; mc = 1'b0; mi = 1'b0; mpc = 12'd0; mport = 4'd0;
      model_run(k, total);
      // Asynchronous reset, checked away from any clock edge.
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk({tag, "_rst_pc"},       {20'd0, pc},        32'd0);
      chk({tag, "_rst_port"},     {28'd0, port_out},  32'd0);
      chk({tag, "_rst_stb"},      {31'd0, port_stb},  32'd0);
      chk({tag, "_rst_we"},       {31'd0, mem_we},    32'd0);
      chk({tag, "_rst_flag_i"},   {31'd0, flag_i},    32'd0);
      chk({tag, "_rst_flag_c"},   {31'd0, flag_c},    32'd0);
      chk({tag, "_rst_mem_addr"}, {24'd0, mem_addr},  32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      done = 0;
      iter = 0;
      while (done < total) begin
         iter++;
         if (!rnd_en || iter > 4 * total + 8) en = 1'b1;
         else en = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         w = mem_we; wa = mem_addr; wd = mem_wdata;
         @(posedge clk);
         if (w) dmem[wa] = wd;
         if (en) done++;
         #1;
      end
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_pc"},        {20'd0, pc},        {20'd0, mpc});
      chk({tag, "_flag_c"},    {31'd0, flag_c},    {31'd0, mc});
      chk({tag, "_flag_i"},    {31'd0, flag_i},    {31'd0, mi});
      chk({tag, "_mem_addr"},  {24'd0, mem_addr},  {24'd0, mm});
      chk({tag, "_mem_wdata"}, {28'd0, mem_wdata}, {28'd0, ma});
      chk({tag, "_port_out"},  {28'd0, port_out},  {28'd0, mport});
      chk({tag, "_outs_left"}, exp_q.size(),       32'd0);
      chk({tag, "_stores_left"}, st_q.size(),      32'd0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== mmem[i]) bad++;
      chk({tag, "_dmem"}, bad, 32'd0);
      exp_q.delete();
      st_q.delete();
   endtask

   initial begin
      init_mem();
      clear_rom();
      repeat (2) @(posedge clk);

      // SEI; LD 5; OUT
      rom[0] = 8'h01; rom[1] = 8'h15; rom[2] = 8'h07;
      run_test("sei_out", 3, 1'b0);

      // Build M=0x3A, compute 5+3, store
      clear_rom();
      rom[0] = 8'h1A; rom[1] = 8'h03; rom[2] = 8'h13; rom[3] = 8'h04;
      rom[4] = 8'h15; rom[5] = 8'h23; rom[6] = 8'h05;
      run_test("store", 7, 1'b0);

      // Carry set, JC taken to 0x123
      clear_rom();
      rom[0] = 8'h1F; rom[1] = 8'h23; rom[2] = 8'h91; rom[3] = 8'h23;
      rom[12'h123] = 8'h07;
      run_test("jc_taken", 4, 1'b0);

      // Carry clear, JC falls through past its operand
      clear_rom();
      rom[0] = 8'h10; rom[1] = 8'h20; rom[2] = 8'h91; rom[3] = 8'h23; rom[4] = 8'h07;
      run_test("jc_untaken", 4, 1'b0);

      // LDR; OUT; JMP 0x000 looping twice
      clear_rom();
      init_mem();
      dmem[0] = 4'h9; mmem[0] = 4'h9;
      rom[0] = 8'h06; rom[1] = 8'h07; rom[2] = 8'h80; rom[3] = 8'h00;
      run_test("ldr_jmp", 8, 1'b0);

      // JMP 0xFFF then NOP wraps pc, with and without stalls
      clear_rom();
      rom[0] = 8'h8F; rom[1] = 8'hFF; rom[12'hFFF] = 8'h00;
      run_test("wrap", 2, 1'b0);
      run_test("wrap_stall", 2, 1'b1);

      for (int r = 0; r < 6; r++) begin
         random_rom();
         init_mem();
         run_test($sformatf("rand%0d", r), 200, (r % 2) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/as5401_core.md
# as5401_core

The as5401_core is a 4-bit accumulator microcontroller core that sits in the user project area behind the Caravel harness. It fetches 8-bit instructions from an external asynchronous program ROM. Data storage is an external 256×4 data memory addressed by an internal 8-bit pointer M. A 4-bit strobed output port drives the GPIO pins that firmware and the bench use for status.

## Interface
Parameters:
- none.

Ports:
- wb_clk_i  in  1  core clock; all state changes on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- en  in  1  run enable; when 0, all architectural state holds and mem_we/port_stb are 0.
- pc  out  12  program counter, which is the ROM address.
- instr  in  8  ROM data for address pc; combinational, valid in the same cycle.
- mem_addr  out  8  data memory address; always equals M.
- mem_wdata  out  4  data memory write data; always equals A.
- mem_we  out  1  data memory write strobe; combinational, asserted only while executing STR.
- mem_rdata  in  4  data memory read data for mem_addr; combinational.
- port_out  out  4  registered output port.
- port_stb  out  1  one-cycle pulse in the cycle after port_out is updated.
- flag_i  out  1  interrupt-enable flag, controlled by SEI/CLI.
- flag_c  out  1  carry flag.

## Operation
Registers: A[3:0], M[7:0], C, I, pc[11:0], jump-high latch JH[3:0], state ∈ {EXEC, OPER}.

In EXEC, instr is decoded and executed, then pc ← pc+1 (unless noted):
- 0x00 NOP.
- 0x01 SEI: I←1.
- 0x02 CLI: I←0.
- 0x03 LML: M[3:0]←A.
- 0x04 LMH: M[7:4]←A.
- 0x05 STR: mem_we=1 this cycle, writing A to memory[M].
- 0x06 LDR: A←mem_rdata.
- 0x07 OUT: port_out←A, port_stb=1 in the next cycle.
- 0x1n LD #n: A←n.
- 0x2n ADD #n: {C,A}←A+n (5-bit sum).
- 0x3n AND #n: A←A&n; C is unchanged.
- 0x4n XOR #n: A←A^n; C is unchanged.
- 0x8h JMP: JH←h, state←OPER.
- 0x9h JC: if C=1, behaves as JMP; otherwise skips the operand byte (pc←pc+2).
- All other opcodes behave as NOP.

In OPER, instr is the operand byte b: pc←{JH,b}, state←EXEC.

Arithmetic:
- pc wraps from 0xFFF to 0x000.
- M and A do not auto-increment.

Reset (asynchronous, wb_rst_i=1): pc=0, A=0, M=0, C=0, I=0, JH=0, state=EXEC, port_out=0, port_stb=0. While reset is asserted, mem_we=0, mem_addr=0 and mem_wdata=0. Reset asserted mid-JMP discards the pending operand.

## Timing
- Single-cycle instructions: 1 clock each. JMP and taken JC: 2 clocks. Untaken JC: 1 clock.
- LDR samples mem_rdata in its EXEC cycle. The loaded A is visible on mem_wdata in the next cycle.
- STR writes A as it stands before that edge. An LDR immediately after STR to the same M returns the new value, which requires the memory to be write-through on the edge.
- LML/LMH take effect on mem_addr in the next cycle.
- port_stb is high exactly one cycle per OUT. Back-to-back OUTs keep it high for consecutive cycles.
- en=0 stalls: pc, state and all registers hold; mem_we=0; port_stb returns to 0 after its current cycle.
- flag outputs are registered and update on the executing edge.

## Test plan
- Reset: hold wb_rst_i high mid-cycle → pc=0x000, port_out=0, port_stb=0, mem_we=0, flag_i=0, flag_c=0 immediately (asynchronous).
- SEI; LD 5; OUT: program 0x01,0x15,0x07 → after 3 cycles flag_i=1, port_out=5, port_stb pulses once.
- LML/LMH/STR: LD 0xA; LML; LD 0x3; LMH; LD 5; ADD 3; STR → mem_addr=0x3A, mem_we=1 with mem_wdata=8 in the STR cycle, flag_c=0.
- Carry: LD 0xF; ADD 3 → A=2, C=1; then JC to 0x123 is taken, with pc=0x123 two cycles later. With C=0, pc advances by 2.
- LDR & JMP: mem_rdata=0x9 at M, LDR; OUT; JMP 0x000 → port_out=9, then pc=0x000. Loop repeats.
- Stall and wrap: en=0 for 5 cycles → no state change. JMP to 0xFFF executing a NOP → pc wraps to 0x000.
